// File: rtl/led_scan_ctrl.sv
// Purpose : scan scheduler and source arbiter for a 6-digit multiplexed 7-segment display.
// Latency : a prescaler tick in cycle T updates the slot outputs and frame_start from cycle T+1.
// Backpressure: none. The block is free-running, and its sources are sampled only at frame boundaries.
//
// Ports:
//   clk, rst        - clock and asynchronous active-low reset
//   src_a, src_b    - 24-bit BCD sources; digit k is bits [4k+3:4k]; src_b is the override
//   req_b           - asks for src_b; takes effect at the next frame boundary
//   blink_mask      - per-digit blink enable; takes effect at the next frame boundary
//   digit_bcd       - BCD code of the active slot (0 when blanked)
//   dig_sel         - one-hot digit select (all zero when blanked)
//   blank           - active slot is blanked
//   grant_b         - the current frame shows src_b
//   frame_start     - one-cycle pulse with the first digit-0 slot of each frame
//
// Optional feature macro: LED_LEADING_ZERO_BLANK_EN (leading-zero blanking).
module led_scan_ctrl #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_SCANS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] src_a,
  input  logic [23:0] src_b,
  input  logic        req_b,
  input  logic [5:0]  blink_mask,
  output logic [3:0]  digit_bcd,
  output logic [5:0]  dig_sel,
  output logic        blank,
  output logic        grant_b,
  output logic        frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

  typedef enum logic {S_INIT, S_SCAN} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [5:0]    mask_q, mask_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_on_q, phase_on_d;
  logic          grant_q, grant_d;
  logic          boundary;
  logic          tick;

  logic [3:0]    digit_q, digit_d;
  logic [5:0]    sel_q, sel_d;
  logic          blank_q, blank_d;
  logic          fs_q;
  logic          lz_slot;
  logic [3:0]    slot_digit;

  assign tick = (pre_q == PRE_LAST);

  // Next-state for the scan position, the frame-latched source and the blink phase
  always_comb begin
    pre_d      = tick ? '0 : pre_q + PW'(1);
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    mask_d     = mask_q;
    grant_d    = grant_q;
    bcnt_d     = bcnt_q;
    phase_on_d = phase_on_q;
    boundary   = 1'b0;
    if (tick) begin
      if (state_q == S_INIT) begin
        state_d  = S_SCAN;
        idx_d    = 3'd0;
        boundary = 1'b1;
      end else begin
        if (bcnt_q == BLINK_LAST) begin
          bcnt_d     = '0;
          phase_on_d = ~phase_on_q;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
        if (idx_q == 3'd5) begin
          idx_d    = 3'd0;
          boundary = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
    end
    if (boundary) begin
      grant_d  = req_b;
      shadow_d = req_b ? src_b : src_a;
      mask_d   = blink_mask;
    end
  end

`ifdef LED_LEADING_ZERO_BLANK_EN
  logic [5:0] lz_q, lz_d, lz_load;

  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 always shows. The mask is frozen together with the shadow value.
  always_comb begin
    lz_load    = '0;
    lz_load[5] = (shadow_d[23:20] == 4'd0);
    for (int k = 4; k >= 1; k--) begin
      lz_load[k] = lz_load[k+1] && (shadow_d[4*k +: 4] == 4'd0);
    end
    lz_d = boundary ? lz_load : lz_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lz_q <= '0;
    else      lz_q <= lz_d;
  end

  assign lz_slot = lz_d[idx_d];
`else
  assign lz_slot = 1'b0;
`endif

  // Slot outputs are derived from next-state values, so they change on the tick edge itself
  always_comb begin
    slot_digit = shadow_d[{idx_d, 2'b00} +: 4];
    digit_d    = slot_digit;
    sel_d      = 6'b000001 << idx_d;
    blank_d    = 1'b0;
    if ((state_d == S_INIT) || (slot_digit > 4'd9) ||
        (mask_d[idx_d] && !phase_on_d) || lz_slot) begin
      digit_d = 4'd0;
      sel_d   = 6'd0;
      blank_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      pre_q      <= '0;
      idx_q      <= 3'd0;
      shadow_q   <= 24'd0;
      mask_q     <= 6'd0;
      bcnt_q     <= '0;
      phase_on_q <= 1'b1;
      grant_q    <= 1'b0;
      digit_q    <= 4'd0;
      sel_q      <= 6'd0;
      blank_q    <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      mask_q     <= mask_d;
      bcnt_q     <= bcnt_d;
      phase_on_q <= phase_on_d;
      grant_q    <= grant_d;
      digit_q    <= digit_d;
      sel_q      <= sel_d;
      blank_q    <= blank_d;
      fs_q       <= boundary;
    end
  end

  assign digit_bcd   = digit_q;
  assign dig_sel     = sel_q;
  assign blank       = blank_q;
  assign grant_b     = grant_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl with SCAN_DIV=4 and BLINK_SCANS=12.
// A slot-level model pushes the expected outputs before each clock edge.
// The expected value is popped and compared one step after the edge.
module tb_led_scan_ctrl;

  localparam int SCAN_DIV    = 4;
  localparam int BLINK_SCANS = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] src_a, src_b;
  logic        req_b;
  logic [5:0]  blink_mask;
  logic [3:0]  digit_bcd;
  logic [5:0]  dig_sel;
  logic        blank, grant_b, frame_start;

  always #5 clk = ~clk;

  led_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLINK_SCANS(BLINK_SCANS)) dut (
    .clk(clk), .rst(rst), .src_a(src_a), .src_b(src_b), .req_b(req_b),
    .blink_mask(blink_mask), .digit_bcd(digit_bcd), .dig_sel(dig_sel),
    .blank(blank), .grant_b(grant_b), .frame_start(frame_start)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] exp_q[$];

  // Model state.
  // m_s counts slots since the first frame began: idx = m_s % 6, and the blink phase is (m_s / BLINK_SCANS) % 2.
  int          m_cnt;
  int          m_s;
  bit          m_started;
  logic [23:0] m_shadow;
  logic [5:0]  m_mask;
  logic        m_grant;

  localparam logic [12:0] RESET_VEC = {4'd0, 6'd0, 1'b1, 1'b0, 1'b0};

  function automatic logic [12:0] observed();
    return {digit_bcd, dig_sel, blank, grant_b, frame_start};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_s = 0; m_started = 0;
    m_shadow = '0; m_mask = '0; m_grant = 1'b0;
    exp_q.delete();
  endtask

  // Called a little after a rising edge. Predicts the outputs after the next edge, then compares them.
  task automatic step(input string tag);
    logic [12:0] e;
    logic [3:0]  d;
    bit          tick, fs, bl, on;
    int          idx;
    tick  = (m_cnt == SCAN_DIV - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    fs    = 1'b0;
    if (tick) begin
      if (!m_started) begin
        m_started = 1'b1;
        m_s = 0;
      end else begin
        m_s++;
      end
      if (m_s % 6 == 0) begin
        fs       = 1'b1;
        m_grant  = req_b;
        m_shadow = req_b ? src_b : src_a;
        m_mask   = blink_mask;
      end
    end
    if (!m_started) begin
      e = {4'd0, 6'd0, 1'b1, m_grant, 1'b0};
    end else begin
      idx = m_s % 6;
      d   = m_shadow[4*idx +: 4];
      on  = ((m_s / BLINK_SCANS) % 2) == 0;
      bl  = (d > 4'd9) || (m_mask[idx] && !on);
`ifdef LED_LEADING_ZERO_BLANK_EN
      if (idx != 0 && (m_shadow >> (4*idx)) == 24'd0) bl = 1'b1;
`endif
      e = bl ? {4'd0, 6'd0, 1'b1, m_grant, fs}
             : {d, 6'(1 << idx), 1'b0, m_grant, fs};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, 32'(observed()), 32'(exp_q.pop_front()));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Step until the first cycle of slot 'target' is showing, with a bounded number of steps.
  task automatic wait_slot(input string tag, input int target);
    int n = 0;
    do begin
      step(tag);
      n++;
    end while (!(m_started && m_cnt == 0 && (m_s % 6) == target) && n < 100);
    if (n >= 100) check({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    rst = 1'b0; src_a = 24'h123456; src_b = 24'h0; req_b = 1'b0; blink_mask = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", 32'(observed()), 32'(RESET_VEC));

    // 1: startup and basic rotation with src_a
    rst = 1'b1;
    model_reset();
    run("t1_scan", 4 + 2 * 6 * SCAN_DIV);

    // 2: override requested mid-frame, shown from the next frame
    src_b = 24'h000042;
    wait_slot("t2_align", 2);
    req_b = 1'b1;
    wait_slot("t2_hold", 0);
    run("t2_override", 2 * 6 * SCAN_DIV);
    req_b = 1'b0;

    // 3: mid-frame src_a change is invisible until the next frame
    src_a = 24'h111111;
    wait_slot("t3_load", 0);
    wait_slot("t3_mid", 3);
    src_a = 24'h999999;
    wait_slot("t3_hold", 0);
    run("t3_new", 6 * SCAN_DIV);

    // 4: blink digits 0 and 1 over two full blink periods
    src_a = 24'h235959;
    blink_mask = 6'b000011;
    wait_slot("t4_load", 0);
    run("t4_blink", 4 * BLINK_SCANS * SCAN_DIV);

    // 5: invalid BCD in digit 3
    blink_mask = 6'd0;
    src_a = 24'h12C456;
    wait_slot("t5_load", 0);
    run("t5_invalid", 6 * SCAN_DIV);

    // 6: asynchronous reset between edges, then first-frame latency and frame period
    wait_slot("t6_align", 2);
    run("t6_pre", 1);
    #3 rst = 1'b0;
    #1 check("t6_async_reset", 32'(observed()), 32'(RESET_VEC));
    #1 req_b = 1'b1;
    src_b = 24'h654321;
    rst = 1'b1;
    model_reset();
    edges = 0;
    while (frame_start !== 1'b1 && edges < 12) begin
      step("t6_release");
      edges++;
    end
    check("t6_first_frame_edges", 32'(edges), 32'd4);
    check("t6_grant_at_start", 32'(grant_b), 32'd1);
    edges = 0;
    do begin
      step("t6_period");
      edges++;
    end while (frame_start !== 1'b1 && edges < 40);
    check("t6_frame_period", 32'(edges), 32'(6 * SCAN_DIV));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
